// File: rtl/dcpu_pkg.sv
// Shared DCPU definitions: interrupt-controller register map, FSM encoding
// and the default interrupt vector base shared with the CPU core.
package dcpu_pkg;

    localparam logic [1:0] ADDR_ENABLE    = 2'd0;
    localparam logic [1:0] ADDR_PENDING   = 2'd1;
    localparam logic [1:0] ADDR_MODE      = 2'd2;
    localparam logic [1:0] ADDR_INSERVICE = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    localparam logic [15:0] DEF_VECTOR_BASE = 16'hFFF0;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dcpu_prio_enc.sv
// Lowest-index-first priority encoder with a valid flag.
module dcpu_prio_enc
    import dcpu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IW    = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_req,
    output logic             o_valid,
    output logic [IW-1:0]    o_idx
);

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        for (int unsigned i = WIDTH; i > 0; i--) begin
            if (i_req[i-1]) o_idx = IW'(i - 1);
        end
    end

endmodule

// File: rtl/dcpu_intc.sv
// DCPU interrupt controller: edge/level channels, fixed priority with
// in-service nesting, and a two-state request handshake with the CPU.
module dcpu_intc
    import dcpu_pkg::*;
#(
    parameter int unsigned    CHANNELS      = 8,
    parameter int unsigned    DW            = 16,
    parameter logic [DW-1:0]  VECTOR_BASE   = DW'(DEF_VECTOR_BASE),
    parameter int unsigned    VECTOR_STRIDE = 1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [CHANNELS-1:0] i_irq,
    input  logic                i_cs,
    input  logic                i_we,
    input  logic [1:0]          i_addr,
    input  logic [DW-1:0]       i_dat,
    output logic [DW-1:0]       o_dat,
    output logic                o_ack,
    output logic                o_int,
    output logic [DW-1:0]       o_vector,
    input  logic                i_int_ack,
    input  logic                i_reti
);

    localparam int unsigned IW = idx_width(CHANNELS);

    logic [CHANNELS-1:0] r_enable;
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] r_mode;
    logic [CHANNELS-1:0] r_inservice;
    logic [CHANNELS-1:0] r_irq_q;
    logic [0:0]          r_state;
    logic [IW-1:0]       r_win;

    logic                w_wr;
    logic                w_is_valid;
    logic [IW-1:0]       w_is_idx;
    logic [CHANNELS-1:0] w_elig;
    logic [CHANNELS-1:0] w_cand;
    logic                w_cand_valid;
    logic [IW-1:0]       w_cand_idx;
    logic                w_win_live;
    logic                w_ack_take;
    logic [CHANNELS-1:0] w_ack_set;
    logic [CHANNELS-1:0] w_reti_clr;
    logic [CHANNELS-1:0] w_w1c;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_edge_next;
    logic [CHANNELS-1:0] w_pending_next;
    logic [CHANNELS-1:0] w_inservice_next;

    assign w_wr = i_cs & i_we;

    dcpu_prio_enc #(
        .WIDTH (CHANNELS),
        .IW    (IW)
    ) u_is_enc (
        .i_req   (r_inservice),
        .o_valid (w_is_valid),
        .o_idx   (w_is_idx)
    );

    // Only channels strictly above the highest-priority in-service one may nest.
    always_comb begin
        w_elig = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_elig[i] = !w_is_valid || (i < 32'(w_is_idx));
        end
    end

    assign w_cand = r_pending & r_enable & w_elig;

    dcpu_prio_enc #(
        .WIDTH (CHANNELS),
        .IW    (IW)
    ) u_cand_enc (
        .i_req   (w_cand),
        .o_valid (w_cand_valid),
        .o_idx   (w_cand_idx)
    );

    assign w_win_live = r_pending[r_win] & r_enable[r_win];
    assign w_ack_take = (r_state == ST_REQ) & i_int_ack;
    assign w_ack_set  = w_ack_take ? (CHANNELS'(1) << r_win) : '0;
    assign w_reti_clr = (i_reti & w_is_valid) ? (CHANNELS'(1) << w_is_idx) : '0;
    assign w_w1c      = (w_wr && i_addr == ADDR_PENDING) ? CHANNELS'(i_dat) : '0;

    // A fresh edge is OR-ed in after the clears so it survives a same-cycle clear.
    assign w_rise           = i_irq & ~r_irq_q;
    assign w_edge_next      = w_rise | (r_pending & ~(w_w1c | w_ack_set));
    assign w_pending_next   = (r_mode & w_edge_next) | (~r_mode & i_irq);
    assign w_inservice_next = (r_inservice & ~w_reti_clr) | w_ack_set;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_enable    <= '0;
            r_pending   <= '0;
            r_mode      <= '0;
            r_inservice <= '0;
            r_irq_q     <= '0;
            r_state     <= ST_IDLE;
            r_win       <= '0;
        end else begin
            r_irq_q     <= i_irq;
            r_pending   <= w_pending_next;
            r_inservice <= w_inservice_next;
            if (w_wr && i_addr == ADDR_ENABLE) r_enable <= CHANNELS'(i_dat);
            if (w_wr && i_addr == ADDR_MODE)   r_mode   <= CHANNELS'(i_dat);
            case (r_state)
                ST_IDLE: begin
                    if (w_cand_valid) begin
                        r_state <= ST_REQ;
                        r_win   <= w_cand_idx;
                    end
                end
                ST_REQ: begin
                    if (i_int_ack || !w_win_live) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_dat = '0;
        if (i_cs) begin
            case (i_addr)
                ADDR_ENABLE:    o_dat = DW'(r_enable);
                ADDR_PENDING:   o_dat = DW'(r_pending);
                ADDR_MODE:      o_dat = DW'(r_mode);
                ADDR_INSERVICE: o_dat = DW'(r_inservice);
                default:        o_dat = '0;
            endcase
        end
    end

    assign o_ack    = i_cs;
    assign o_int    = (r_state == ST_REQ);
    assign o_vector = (r_state == ST_REQ)
                    ? VECTOR_BASE + DW'(r_win) * DW'(VECTOR_STRIDE)
                    : '0;

endmodule

// File: tb/tb_dcpu_intc.sv
// Self-checking bench for dcpu_intc: expected vectors are queued when a
// request is stimulated and popped when the controller raises o_int.
module tb_dcpu_intc;

    logic        clk;
    logic        i_reset;
    logic [7:0]  i_irq;
    logic        i_cs;
    logic        i_we;
    logic [1:0]  i_addr;
    logic [15:0] i_dat;
    logic [15:0] o_dat;
    logic        o_ack;
    logic        o_int;
    logic [15:0] o_vector;
    logic        i_int_ack;
    logic        i_reti;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_vec_q[$];

    dcpu_intc #(
        .CHANNELS      (8),
        .DW            (16),
        .VECTOR_BASE   (16'hFFF0),
        .VECTOR_STRIDE (1)
    ) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_irq     (i_irq),
        .i_cs      (i_cs),
        .i_we      (i_we),
        .i_addr    (i_addr),
        .i_dat     (i_dat),
        .o_dat     (o_dat),
        .o_ack     (o_ack),
        .o_int     (o_int),
        .o_vector  (o_vector),
        .i_int_ack (i_int_ack),
        .i_reti    (i_reti)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // All stimulus and sampling happens 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [15:0] data);
        i_cs = 1'b1; i_we = 1'b1; i_addr = addr; i_dat = data;
        tick();
        i_cs = 1'b0; i_we = 1'b0; i_dat = '0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [15:0] data);
        i_cs = 1'b1; i_we = 1'b0; i_addr = addr;
        #1;
        data = o_dat;
        i_cs = 1'b0;
    endtask

    task automatic pulse_ack();
        i_int_ack = 1'b1;
        tick();
        i_int_ack = 1'b0;
    endtask

    task automatic pulse_reti();
        i_reti = 1'b1;
        tick();
        i_reti = 1'b0;
    endtask

    task automatic wait_int(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_int) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        checks++;
        if (o_int !== 1'b0) begin errors++; $display("FAIL reset_int: got %b want 0", o_int); end
        checks++;
        if (o_vector !== 16'h0) begin errors++; $display("FAIL reset_vec: got %h want 0000", o_vector); end
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            checks++;
            if (rd !== 16'h0) begin errors++; $display("FAIL reset_reg%0d: got %h want 0000", a, rd); end
        end
        i_addr = 2'd0;
        #1;
        checks++;
        if (o_dat !== 16'h0 || o_ack !== 1'b0) begin
            errors++; $display("FAIL unselected_bus: dat %h ack %b want 0000 0", o_dat, o_ack);
        end
    endtask

    task automatic test_edge_basic();
        logic [15:0] rd;
        logic [15:0] exp;
        bus_write(2'd0, 16'h0001);
        bus_write(2'd2, 16'h0001);
        i_irq[0] = 1'b1;
        exp_vec_q.push_back(16'hFFF0);
        tick();
        checks++;
        if (o_int !== 1'b0) begin errors++; $display("FAIL edge_lat1: o_int %b want 0", o_int); end
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 16'h0001) begin errors++; $display("FAIL edge_pending: got %h want 0001", rd); end
        tick();
        checks++;
        if (o_int !== 1'b1) begin errors++; $display("FAIL edge_lat2: o_int %b want 1", o_int); end
        if (o_int === 1'b1 && exp_vec_q.size() > 0) begin
            exp = exp_vec_q.pop_front();
            checks++;
            if (o_vector !== exp) begin errors++; $display("FAIL edge_vec: got %h want %h", o_vector, exp); end
        end
        i_irq[0] = 1'b0;
        pulse_ack();
        checks++;
        if (o_int !== 1'b0) begin errors++; $display("FAIL edge_ack_int: o_int %b want 0", o_int); end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 16'h0001) begin errors++; $display("FAIL edge_inservice: got %h want 0001", rd); end
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL edge_pend_clr: got %h want 0000", rd); end
        pulse_reti();
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL edge_reti: got %h want 0000", rd); end
    endtask

    task automatic test_priority();
        logic [15:0] rd;
        logic [15:0] exp;
        bit got;
        bus_write(2'd0, 16'h000C);
        bus_write(2'd2, 16'h00FF);
        i_irq[3:2] = 2'b11;
        exp_vec_q.push_back(16'hFFF2);
        exp_vec_q.push_back(16'hFFF3);
        tick();
        wait_int(got);
        checks++;
        if (!got) begin errors++; $display("FAIL prio_first_int: o_int 0 want 1 within 20 cycles"); end
        else begin
            exp = exp_vec_q.pop_front();
            checks++;
            if (o_vector !== exp) begin errors++; $display("FAIL prio_first_vec: got %h want %h", o_vector, exp); end
        end
        pulse_ack();
        tick();
        tick();
        checks++;
        if (o_int !== 1'b0) begin errors++; $display("FAIL prio_blocked: o_int %b want 0", o_int); end
        pulse_reti();
        wait_int(got);
        checks++;
        if (!got) begin errors++; $display("FAIL prio_second_int: o_int 0 want 1 within 20 cycles"); end
        else begin
            exp = exp_vec_q.pop_front();
            checks++;
            if (o_vector !== exp) begin errors++; $display("FAIL prio_second_vec: got %h want %h", o_vector, exp); end
        end
        pulse_ack();
        pulse_reti();
        i_irq[3:2] = 2'b00;
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL prio_pend_end: got %h want 0000", rd); end
    endtask

    task automatic test_nesting();
        logic [15:0] rd;
        logic [15:0] exp;
        bit got;
        bus_write(2'd0, 16'h00FF);
        i_irq[3] = 1'b1;
        exp_vec_q.push_back(16'hFFF3);
        tick();
        wait_int(got);
        checks++;
        if (!got) begin errors++; $display("FAIL nest_outer_int: o_int 0 want 1 within 20 cycles"); end
        else begin
            exp = exp_vec_q.pop_front();
            checks++;
            if (o_vector !== exp) begin errors++; $display("FAIL nest_outer_vec: got %h want %h", o_vector, exp); end
        end
        pulse_ack();
        i_irq[1] = 1'b1;
        exp_vec_q.push_back(16'hFFF1);
        tick();
        wait_int(got);
        checks++;
        if (!got) begin errors++; $display("FAIL nest_inner_int: o_int 0 want 1 within 20 cycles"); end
        else begin
            exp = exp_vec_q.pop_front();
            checks++;
            if (o_vector !== exp) begin errors++; $display("FAIL nest_inner_vec: got %h want %h", o_vector, exp); end
        end
        pulse_ack();
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 16'h000A) begin errors++; $display("FAIL nest_inservice: got %h want 000A", rd); end
        i_irq[5] = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (o_int !== 1'b0) begin errors++; $display("FAIL nest_ch5_hold1: o_int %b want 0", o_int); end
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 16'h0020) begin errors++; $display("FAIL nest_ch5_pending: got %h want 0020", rd); end
        pulse_reti();
        tick();
        tick();
        checks++;
        if (o_int !== 1'b0) begin errors++; $display("FAIL nest_ch5_hold2: o_int %b want 0", o_int); end
        exp_vec_q.push_back(16'hFFF5);
        pulse_reti();
        wait_int(got);
        checks++;
        if (!got) begin errors++; $display("FAIL nest_ch5_int: o_int 0 want 1 within 20 cycles"); end
        else begin
            exp = exp_vec_q.pop_front();
            checks++;
            if (o_vector !== exp) begin errors++; $display("FAIL nest_ch5_vec: got %h want %h", o_vector, exp); end
        end
        pulse_ack();
        pulse_reti();
        i_irq = '0;
        pulse_ack();
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL idle_ack_ignored: got %h want 0000", rd); end
    endtask

    task automatic test_reti_ack_same_cycle();
        logic [15:0] rd;
        logic [15:0] exp;
        bit got;
        i_irq[3] = 1'b1;
        exp_vec_q.push_back(16'hFFF3);
        tick();
        wait_int(got);
        if (got) void'(exp_vec_q.pop_front());
        pulse_ack();
        i_irq[1] = 1'b1;
        exp_vec_q.push_back(16'hFFF1);
        tick();
        wait_int(got);
        checks++;
        if (!got) begin errors++; $display("FAIL same_int: o_int 0 want 1 within 20 cycles"); end
        else begin
            exp = exp_vec_q.pop_front();
            checks++;
            if (o_vector !== exp) begin errors++; $display("FAIL same_vec: got %h want %h", o_vector, exp); end
        end
        i_int_ack = 1'b1;
        i_reti = 1'b1;
        tick();
        i_int_ack = 1'b0;
        i_reti = 1'b0;
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 16'h0002) begin errors++; $display("FAIL same_inservice: got %h want 0002", rd); end
        pulse_reti();
        i_irq = '0;
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL same_final: got %h want 0000", rd); end
    endtask

    task automatic test_level_withdraw();
        logic [15:0] rd;
        logic [15:0] exp;
        bit got;
        bus_write(2'd2, 16'h00EF);
        i_irq[4] = 1'b1;
        exp_vec_q.push_back(16'hFFF4);
        tick();
        wait_int(got);
        checks++;
        if (!got) begin errors++; $display("FAIL level_int: o_int 0 want 1 within 20 cycles"); end
        else begin
            exp = exp_vec_q.pop_front();
            checks++;
            if (o_vector !== exp) begin errors++; $display("FAIL level_vec: got %h want %h", o_vector, exp); end
        end
        i_irq[4] = 1'b0;
        for (int i = 0; i < 4 && o_int; i++) tick();
        checks++;
        if (o_int !== 1'b0 || o_vector !== 16'h0) begin
            errors++; $display("FAIL level_withdraw: int %b vec %h want 0 0000", o_int, o_vector);
        end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL level_inservice: got %h want 0000", rd); end
        bus_write(2'd0, 16'h0000);
        i_irq[4] = 1'b1;
        tick();
        bus_write(2'd1, 16'h0010);
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 16'h0010) begin errors++; $display("FAIL level_w1c_ignored: got %h want 0010", rd); end
        i_irq[4] = 1'b0;
        tick();
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL level_follow: got %h want 0000", rd); end
    endtask

    task automatic test_w1c_race();
        logic [15:0] rd;
        bus_write(2'd2, 16'h00FF);
        i_irq[0] = 1'b1;
        bus_write(2'd1, 16'h0001);
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 16'h0001) begin errors++; $display("FAIL w1c_race: got %h want 0001", rd); end
        bus_write(2'd1, 16'h0001);
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 16'h0000) begin errors++; $display("FAIL w1c_plain: got %h want 0000", rd); end
        i_irq[0] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_req();
        logic [15:0] rd;
        logic [15:0] exp;
        bit got;
        bus_write(2'd0, 16'h00FF);
        i_irq[2] = 1'b1;
        exp_vec_q.push_back(16'hFFF2);
        tick();
        wait_int(got);
        checks++;
        if (!got) begin errors++; $display("FAIL rstreq_int: o_int 0 want 1 within 20 cycles"); end
        else begin
            exp = exp_vec_q.pop_front();
            checks++;
            if (o_vector !== exp) begin errors++; $display("FAIL rstreq_vec: got %h want %h", o_vector, exp); end
        end
        i_reset = 1'b1;
        i_int_ack = 1'b1;
        i_cs = 1'b1; i_we = 1'b1; i_addr = 2'd2; i_dat = 16'h00FF;
        tick();
        i_reset = 1'b0;
        i_int_ack = 1'b0;
        i_cs = 1'b0; i_we = 1'b0; i_dat = '0;
        checks++;
        if (o_int !== 1'b0 || o_vector !== 16'h0) begin
            errors++; $display("FAIL rstreq_out: int %b vec %h want 0 0000", o_int, o_vector);
        end
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            checks++;
            if (rd !== 16'h0) begin errors++; $display("FAIL rstreq_reg%0d: got %h want 0000", a, rd); end
        end
        i_irq = '0;
        checks++;
        if (exp_vec_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d vectors left want 0", exp_vec_q.size());
        end
    endtask

    initial begin
        i_reset = 1'b0; i_irq = '0; i_cs = 1'b0; i_we = 1'b0;
        i_addr = '0; i_dat = '0; i_int_ack = 1'b0; i_reti = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_edge_basic();
        test_priority();
        test_nesting();
        test_reti_ack_same_cycle();
        test_level_withdraw();
        test_w1c_race();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
